// File: rtl/tgm_pkg.sv
// tgm_pkg: shared types and default widths for the multi-queue token-bucket meter.
//   state_t    : metering FSM state {INIT, RUN}
//   *_D        : default parameter values for tgm_mq / tgm_bucket
//   sum_w()    : width of the signed token sum (TOKEN_W + 2, never wraps)
package tgm_pkg;
    localparam int N_QUEUE_D = 8;
    localparam int QID_W_D   = 3;
    localparam int TOKEN_W_D = 16;
    localparam int LEN_W_D   = 12;
    localparam int STAT_W_D  = 32;

    typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

    function automatic int sum_w(input int token_w);
        return token_w + 2;
    endfunction
endpackage

// File: rtl/tgm_bucket.sv
// tgm_bucket: one token bucket with its rate/size config, add/subtract/clamp and request compare.
//   clk, rst          : clock, asynchronous active-high reset
//   run_i             : metering active this cycle (RUN and no test_stop)
//   load_i            : INIT->RUN this cycle, preload min(rate, size)
//   tick_i, grant_i   : slot tick, grant to this queue
//   pkt_valid_i/len_i : head packet of this queue
//   cfg_we_i/rate/size: config write for this queue
//   req_o             : registered generation request
//   uf_o              : grant exceeded tokens this cycle (combinational)
module tgm_bucket
    import tgm_pkg::*;
#(
    parameter int TOKEN_W = TOKEN_W_D,
    parameter int LEN_W   = LEN_W_D
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run_i,
    input  logic               load_i,
    input  logic               tick_i,
    input  logic               grant_i,
    input  logic               pkt_valid_i,
    input  logic [LEN_W-1:0]   pkt_len_i,
    input  logic               cfg_we_i,
    input  logic [TOKEN_W-1:0] cfg_rate_i,
    input  logic [TOKEN_W-1:0] cfg_size_i,
    output logic               req_o,
    output logic               uf_o
);
    localparam int SW = sum_w(TOKEN_W);

    logic [TOKEN_W-1:0] rt_q, rt_d, rate_q, rate_d, size_q, size_d, add, lim;
    logic [LEN_W-1:0]   cons;
    logic [SW-1:0]      sum;
    logic               neg, over, req_d, req_q;

    always_comb begin
        add    = tick_i ? rate_q : '0;
        cons   = grant_i ? pkt_len_i : '0;
        // zero-extended operands; the top bit is the sign of the true result
        sum    = SW'(rt_q) + SW'(add) - SW'(cons);
        neg    = sum[SW-1];
        over   = !neg && (sum > SW'(size_q));
        lim    = (rate_q < size_q) ? rate_q : size_q;
        rt_d   = run_i ? (neg ? '0 : over ? size_q : sum[TOKEN_W-1:0]) : load_i ? lim : '0;
        // a granted queue's head length is stale for one cycle, so never request right after
        req_d  = run_i && pkt_valid_i && (rt_d >= TOKEN_W'(pkt_len_i)) && !grant_i;
        rate_d = cfg_we_i ? cfg_rate_i : rate_q;
        size_d = cfg_we_i ? cfg_size_i : size_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rt_q   <= '0;
            rate_q <= '0;
            size_q <= '0;
            req_q  <= 1'b0;
        end else begin
            rt_q   <= rt_d;
            rate_q <= rate_d;
            size_q <= size_d;
            req_q  <= req_d;
        end
    end

    assign req_o = req_q;
    assign uf_o  = run_i && neg;
endmodule

// File: rtl/tgm_mq.sv
// tgm_mq: multi-queue token-bucket traffic generation meter, one bucket per TSN queue.
//   clk, rst               : clock, asynchronous active-high reset
//   test_stop              : level, stop metering and empty all buckets
//   lau_update_finish      : level, start metering
//   slot_shift             : toggles once per slot, each edge is a tick
//   cfg_wr/qid/tb_rate/size: runtime per-queue rate and depth write
//   pkt_valid, pkt_len     : per-queue head packet (len of q at [q*LEN_W +: LEN_W])
//   sel_valid, sel_qid     : grant from TSM
//   out_tgm_req            : registered per-queue request
//   err_underflow          : 1-cycle pulse when a grant exceeded the bucket
//   stat_qid/grant_cnt     : grant counter read (only with TGM_STATS_EN defined)
// Optional feature macro: TGM_STATS_EN
module tgm_mq
    import tgm_pkg::*;
#(
    parameter int N_QUEUE = N_QUEUE_D,
    parameter int QID_W   = QID_W_D,
    parameter int TOKEN_W = TOKEN_W_D,
    parameter int LEN_W   = LEN_W_D,
    parameter int STAT_W  = STAT_W_D
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     test_stop,
    input  logic                     lau_update_finish,
    input  logic                     slot_shift,
    input  logic                     cfg_wr,
    input  logic [QID_W-1:0]         cfg_qid,
    input  logic [TOKEN_W-1:0]       cfg_tb_rate,
    input  logic [TOKEN_W-1:0]       cfg_tb_size,
    input  logic [N_QUEUE-1:0]       pkt_valid,
    input  logic [N_QUEUE*LEN_W-1:0] pkt_len,
    input  logic                     sel_valid,
    input  logic [QID_W-1:0]         sel_qid,
    output logic [N_QUEUE-1:0]       out_tgm_req,
    output logic                     err_underflow,
    input  logic [QID_W-1:0]         stat_qid,
    output logic [STAT_W-1:0]        stat_grant_cnt
);
    state_t             state_q, state_d;
    logic               slot_shift_q, tick, run, go, stop, err_d, err_q;
    logic [N_QUEUE-1:0] grant, cfg_we, uf;

    always_comb begin
        tick    = slot_shift ^ slot_shift_q;
        stop    = (state_q == RUN) && test_stop;
        run     = (state_q == RUN) && !test_stop;
        // test_stop held in INIT keeps the meter parked there
        go      = (state_q == INIT) && lau_update_finish && !test_stop;
        state_d = (run || go) ? RUN : INIT;
        err_d   = |uf;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= INIT;
            slot_shift_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_shift_q <= slot_shift;
            err_q        <= err_d;
        end
    end

    assign err_underflow = err_q;

    for (genvar i = 0; i < N_QUEUE; i++) begin : g_q
        // out-of-range qids never match any bucket, so they are ignored naturally
        assign grant[i]  = sel_valid && (sel_qid == QID_W'(i));
        assign cfg_we[i] = cfg_wr && (cfg_qid == QID_W'(i));
        tgm_bucket #(.TOKEN_W(TOKEN_W), .LEN_W(LEN_W)) u_bucket (
            .clk        (clk),
            .rst        (rst),
            .run_i      (run),
            .load_i     (go),
            .tick_i     (tick),
            .grant_i    (grant[i]),
            .pkt_valid_i(pkt_valid[i]),
            .pkt_len_i  (pkt_len[i*LEN_W +: LEN_W]),
            .cfg_we_i   (cfg_we[i]),
            .cfg_rate_i (cfg_tb_rate),
            .cfg_size_i (cfg_tb_size),
            .req_o      (out_tgm_req[i]),
            .uf_o       (uf[i])
        );
    end

`ifdef TGM_STATS_EN
    logic [STAT_W-1:0] cnt_q [N_QUEUE];
    logic [STAT_W-1:0] cnt_d [N_QUEUE];

    always_comb begin
        for (int k = 0; k < N_QUEUE; k++)
            cnt_d[k] = stop ? '0 : (run && grant[k] && !(&cnt_q[k])) ? cnt_q[k] + 1'b1 : cnt_q[k];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N_QUEUE; k++) cnt_q[k] <= '0;
        end else begin
            for (int k = 0; k < N_QUEUE; k++) cnt_q[k] <= cnt_d[k];
        end
    end

    assign stat_grant_cnt = (int'(stat_qid) < N_QUEUE) ? cnt_q[stat_qid] : '0;
`else
    logic unused_stat;
    assign unused_stat    = ^stat_qid;
    assign stat_grant_cnt = '0;
`endif
endmodule
